// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX types: decoded control word layout, NOP encoding, and the register/opcode constants.
package id_ex_stage_pkg;

    typedef struct packed {
        logic       shift_imm;
        logic [3:0] alu_op;
        logic       m_size;
        logic       m_enable;
        logic       m_rw;
        logic       load;
        logic       s;
        logic       rf_en;
        logic       b_instr;
        logic       bl;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = ctrl_word_t'(13'b0);
    localparam logic [3:0] REG_PC   = 4'hF;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0010;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard generator, purely combinational; reusable by the forwarding unit.
// hz_stall folds in the downstream freeze so upstream stages see a single hold request.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_load_i,
    input  logic       ex_rf_en_i,
    input  logic [3:0] ex_rd_i,
    input  logic [3:0] id_rn_i,
    input  logic [3:0] id_rm_i,
    input  logic       id_uses_rn_i,
    input  logic       id_uses_rm_i,
    input  logic       mem_busy_i,
    output logic       lu_o,
    output logic       hz_stall_o
);

    logic rn_hit;
    logic rm_hit;

    assign rn_hit = id_uses_rn_i && (id_rn_i == ex_rd_i);
    assign rm_hit = id_uses_rm_i && (id_rm_i == ex_rd_i);

    // Loads into the PC are resolved by the branch/flush path, never by stalling.
    assign lu_o = ex_valid_i && ex_load_i && ex_rf_en_i && (ex_rd_i != REG_PC)
                  && (rn_hit || rm_hit);

    assign hz_stall_o = lu_o || mem_busy_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-cycle ID->EX latency with load-use bubble insertion.
// MEM_busy freezes the whole register; ID_flush or a load-use hazard loads a NOP bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             ID_shift_imm,
    input  logic             m_size,
    input  logic             m_enable,
    input  logic             m_rw,
    input  logic             ID_Load_Inst,
    input  logic             S,
    input  logic             ID_RF_enable,
    input  logic             ID_B_instr,
    input  logic             BL,
    input  logic [3:0]       ID_ALU_Op,
    input  logic [3:0]       ID_Rn,
    input  logic [3:0]       ID_Rm,
    input  logic [3:0]       ID_Rd,
    input  logic             ID_uses_Rn,
    input  logic             ID_uses_Rm,
    input  logic [DW-1:0]    ID_A,
    input  logic [DW-1:0]    ID_B,
    input  logic [DW-1:0]    ID_D,
    input  logic [11:0]      ID_shifter,
    input  logic [DW-1:0]    ID_PC,
    input  logic             ID_flush,
    input  logic             MEM_busy,
    output logic             EX_shift_imm,
    output logic             EX_m_size,
    output logic             EX_m_enable,
    output logic             EX_m_rw,
    output logic             EX_Load_Inst,
    output logic             EX_S,
    output logic             EX_RF_enable,
    output logic             EX_B_instr,
    output logic             EX_BL,
    output logic [3:0]       EX_ALU_Op,
    output logic [3:0]       EX_Rn,
    output logic [3:0]       EX_Rm,
    output logic [3:0]       EX_Rd,
    output logic [DW-1:0]    EX_A,
    output logic [DW-1:0]    EX_B,
    output logic [DW-1:0]    EX_D,
    output logic [DW-1:0]    EX_PC,
    output logic [11:0]      EX_shifter,
    output logic             EX_valid,
    output logic             hz_stall,
    output logic [CNT_W-1:0] stall_count
);

    ctrl_word_t id_ctrl;
    ctrl_word_t ctrl_q, ctrl_d;
    logic [3:0]       rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
    logic [DW-1:0]    a_q, a_d, b_q, b_d, d_q, d_d, pc_q, pc_d;
    logic [11:0]      shifter_q, shifter_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;

    assign id_ctrl = {ID_shift_imm, ID_ALU_Op, m_size, m_enable, m_rw,
                      ID_Load_Inst, S, ID_RF_enable, ID_B_instr, BL};

    hazard_detect u_hazard_detect (
        .ex_valid_i   (valid_q),
        .ex_load_i    (ctrl_q.load),
        .ex_rf_en_i   (ctrl_q.rf_en),
        .ex_rd_i      (rd_q),
        .id_rn_i      (ID_Rn),
        .id_rm_i      (ID_Rm),
        .id_uses_rn_i (ID_uses_Rn),
        .id_uses_rm_i (ID_uses_Rm),
        .mem_busy_i   (MEM_busy),
        .lu_o         (lu),
        .hz_stall_o   (hz_stall)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        rn_d      = rn_q;
        rm_d      = rm_q;
        rd_d      = rd_q;
        a_d       = a_q;
        b_d       = b_q;
        d_d       = d_q;
        pc_d      = pc_q;
        shifter_d = shifter_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        if (!MEM_busy) begin
            if (ID_flush || lu) begin
                ctrl_d    = CTRL_NOP;
                rn_d      = '0;
                rm_d      = '0;
                rd_d      = '0;
                a_d       = '0;
                b_d       = '0;
                d_d       = '0;
                pc_d      = '0;
                shifter_d = '0;
                valid_d   = 1'b0;
                // Only genuine load-use bubbles are counted; a flush takes precedence.
                if (!ID_flush && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                ctrl_d    = id_ctrl;
                rn_d      = ID_Rn;
                rm_d      = ID_Rm;
                rd_d      = ID_Rd;
                a_d       = ID_A;
                b_d       = ID_B;
                d_d       = ID_D;
                pc_d      = ID_PC;
                shifter_d = ID_shifter;
                valid_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            ctrl_q    <= CTRL_NOP;
            rn_q      <= '0;
            rm_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            pc_q      <= '0;
            shifter_q <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rn_q      <= rn_d;
            rm_q      <= rm_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            d_q       <= d_d;
            pc_q      <= pc_d;
            shifter_q <= shifter_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign EX_shift_imm = ctrl_q.shift_imm;
    assign EX_ALU_Op    = ctrl_q.alu_op;
    assign EX_m_size    = ctrl_q.m_size;
    assign EX_m_enable  = ctrl_q.m_enable;
    assign EX_m_rw      = ctrl_q.m_rw;
    assign EX_Load_Inst = ctrl_q.load;
    assign EX_S         = ctrl_q.s;
    assign EX_RF_enable = ctrl_q.rf_en;
    assign EX_B_instr   = ctrl_q.b_instr;
    assign EX_BL        = ctrl_q.bl;
    assign EX_Rn        = rn_q;
    assign EX_Rm        = rm_q;
    assign EX_Rd        = rd_q;
    assign EX_A         = a_q;
    assign EX_B         = b_q;
    assign EX_D         = d_q;
    assign EX_PC        = pc_q;
    assign EX_shifter   = shifter_q;
    assign EX_valid     = valid_q;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run against a reference model.
module tb_id_ex_stage;

    localparam int DW    = 32;
    localparam int CNT_W = 4;

    // Control word bit layout: [12] shift_imm, [11:8] alu_op, [7] m_size, [6] m_enable,
    // [5] m_rw, [4] load, [3] s, [2] rf_en, [1] b_instr, [0] bl.
    localparam logic [12:0] C_ADD = 13'b0_0100_00000100;
    localparam logic [12:0] C_LDR = 13'b0_0100_01010100;

    typedef struct packed {
        logic [12:0]   ctrl;
        logic [3:0]    rn;
        logic [3:0]    rm;
        logic [3:0]    rd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] d;
        logic [DW-1:0] pc;
        logic [11:0]   sh;
        logic          valid;
    } ex_t;

    logic CLK = 1'b0;
    logic CLR;
    logic [12:0] id_ctrl;
    logic [3:0] ID_Rn, ID_Rm, ID_Rd;
    logic ID_uses_Rn, ID_uses_Rm;
    logic [DW-1:0] ID_A, ID_B, ID_D, ID_PC;
    logic [11:0] ID_shifter;
    logic ID_flush, MEM_busy;

    logic EX_shift_imm, EX_m_size, EX_m_enable, EX_m_rw, EX_Load_Inst, EX_S;
    logic EX_RF_enable, EX_B_instr, EX_BL, EX_valid, hz_stall;
    logic [3:0] EX_ALU_Op, EX_Rn, EX_Rm, EX_Rd;
    logic [DW-1:0] EX_A, EX_B, EX_D, EX_PC;
    logic [11:0] EX_shifter;
    logic [CNT_W-1:0] stall_count;

    ex_t obs;
    ex_t exp_ex;
    logic [CNT_W-1:0] exp_cnt;
    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .CLR(CLR),
        .ID_shift_imm(id_ctrl[12]), .m_size(id_ctrl[7]), .m_enable(id_ctrl[6]),
        .m_rw(id_ctrl[5]), .ID_Load_Inst(id_ctrl[4]), .S(id_ctrl[3]),
        .ID_RF_enable(id_ctrl[2]), .ID_B_instr(id_ctrl[1]), .BL(id_ctrl[0]),
        .ID_ALU_Op(id_ctrl[11:8]),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_uses_Rn(ID_uses_Rn), .ID_uses_Rm(ID_uses_Rm),
        .ID_A(ID_A), .ID_B(ID_B), .ID_D(ID_D), .ID_shifter(ID_shifter), .ID_PC(ID_PC),
        .ID_flush(ID_flush), .MEM_busy(MEM_busy),
        .EX_shift_imm(EX_shift_imm), .EX_m_size(EX_m_size), .EX_m_enable(EX_m_enable),
        .EX_m_rw(EX_m_rw), .EX_Load_Inst(EX_Load_Inst), .EX_S(EX_S),
        .EX_RF_enable(EX_RF_enable), .EX_B_instr(EX_B_instr), .EX_BL(EX_BL),
        .EX_ALU_Op(EX_ALU_Op), .EX_Rn(EX_Rn), .EX_Rm(EX_Rm), .EX_Rd(EX_Rd),
        .EX_A(EX_A), .EX_B(EX_B), .EX_D(EX_D), .EX_PC(EX_PC), .EX_shifter(EX_shifter),
        .EX_valid(EX_valid), .hz_stall(hz_stall), .stall_count(stall_count)
    );

    assign obs = {EX_shift_imm, EX_ALU_Op, EX_m_size, EX_m_enable, EX_m_rw, EX_Load_Inst,
                  EX_S, EX_RF_enable, EX_B_instr, EX_BL, EX_Rn, EX_Rm, EX_Rd,
                  EX_A, EX_B, EX_D, EX_PC, EX_shifter, EX_valid};

    // Load-use rule evaluated on the modelled EX instruction and current ID inputs.
    function automatic logic ref_lu();
        return exp_ex.valid && exp_ex.ctrl[4] && exp_ex.ctrl[2] && (exp_ex.rd != 4'hF) &&
               ((ID_uses_Rn && ID_Rn == exp_ex.rd) || (ID_uses_Rm && ID_Rm == exp_ex.rd));
    endfunction

    // Advance the reference model by one edge, then let the DUT take the same edge.
    task automatic tick();
        ex_t nxt;
        nxt = exp_ex;
        if (!CLR) begin
            nxt = '0;
            exp_cnt = '0;
        end else if (!MEM_busy) begin
            if (ID_flush) begin
                nxt = '0;
            end else if (ref_lu()) begin
                nxt = '0;
                if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            end else begin
                nxt = '{ctrl: id_ctrl, rn: ID_Rn, rm: ID_Rm, rd: ID_Rd, a: ID_A, b: ID_B,
                        d: ID_D, pc: ID_PC, sh: ID_shifter, valid: 1'b1};
            end
        end
        @(posedge CLK);
        #1;
        exp_ex = nxt;
    endtask

    task automatic set_id(input logic [12:0] c, input logic [3:0] rn, input logic [3:0] rm,
                          input logic [3:0] rd, input logic urn, input logic urm);
        id_ctrl    = c;
        ID_Rn      = rn;
        ID_Rm      = rm;
        ID_Rd      = rd;
        ID_uses_Rn = urn;
        ID_uses_Rm = urm;
        ID_A       = $urandom;
        ID_B       = $urandom;
        ID_D       = $urandom;
        ID_PC      = $urandom;
        ID_shifter = 12'($urandom);
    endtask

    task automatic test_reset();
        CLR = 1'b0; ID_flush = 1'b0; MEM_busy = 1'b0;
        set_id(13'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1);
        tick();
        #1;
        vectors++;
        if (obs !== ex_t'(0)) begin
            miscompares++; $display("FAIL reset_ex: got %h expected 0", obs);
        end
        vectors++;
        if (stall_count !== '0) begin
            miscompares++; $display("FAIL reset_cnt: got %0d expected 0", stall_count);
        end
        vectors++;
        if (hz_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_hz: got %0b expected 0", hz_stall);
        end
        CLR = 1'b1;
    endtask

    task automatic test_pass_through();
        set_id(C_ADD, 4'd2, 4'd5, 4'd5, 1'b1, 1'b1);
        ID_shifter = 12'h005;
        tick();
        vectors++;
        if (EX_ALU_Op !== 4'b0100 || EX_Rd !== 4'd5 || EX_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_add: got op=%b rd=%0d v=%0b expected op=0100 rd=5 v=1",
                     EX_ALU_Op, EX_Rd, EX_valid);
        end
        vectors++;
        if (obs !== exp_ex) begin
            miscompares++; $display("FAIL pass_all: got %h expected %h", obs, exp_ex);
        end
    endtask

    task automatic test_load_use();
        set_id(C_LDR, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0);
        tick();
        set_id(C_ADD, 4'd3, 4'd2, 4'd4, 1'b1, 1'b1);
        #1;
        vectors++;
        if (hz_stall !== 1'b1) begin
            miscompares++; $display("FAIL lu_hz: got %0b expected 1", hz_stall);
        end
        tick();
        vectors++;
        if (EX_valid !== 1'b0 || stall_count !== 4'd1) begin
            miscompares++;
            $display("FAIL lu_bubble: got v=%0b cnt=%0d expected v=0 cnt=1", EX_valid, stall_count);
        end
        vectors++;
        if (hz_stall !== 1'b0) begin
            miscompares++; $display("FAIL lu_release: got %0b expected 0", hz_stall);
        end
        tick();
        vectors++;
        if (EX_Rn !== 4'd3 || EX_valid !== 1'b1 || obs !== exp_ex) begin
            miscompares++; $display("FAIL lu_enter: got %h expected %h", obs, exp_ex);
        end
        // Reset while a stall is pending: cleared EX drops hz_stall.
        set_id(C_LDR, 4'd1, 4'd0, 4'd6, 1'b1, 1'b0);
        tick();
        set_id(C_ADD, 4'd6, 4'd2, 4'd4, 1'b1, 1'b0);
        CLR = 1'b0;
        tick();
        vectors++;
        if (hz_stall !== 1'b0 || EX_valid !== 1'b0 || stall_count !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_stall: got hz=%0b v=%0b cnt=%0d expected 0 0 0",
                     hz_stall, EX_valid, stall_count);
        end
        CLR = 1'b1;
    endtask

    task automatic test_no_false_stall();
        set_id(C_LDR, 4'd1, 4'd0, 4'hF, 1'b1, 1'b0);
        tick();
        set_id(C_ADD, 4'hF, 4'hF, 4'd4, 1'b1, 1'b1);
        #1;
        vectors++;
        if (hz_stall !== 1'b0) begin
            miscompares++; $display("FAIL nfs_r15_hz: got %0b expected 0", hz_stall);
        end
        tick();
        vectors++;
        if (EX_valid !== 1'b1 || EX_Rd !== 4'd4 || stall_count !== exp_cnt) begin
            miscompares++; $display("FAIL nfs_r15_ex: got v=%0b rd=%0d expected v=1 rd=4", EX_valid, EX_Rd);
        end
        set_id(C_LDR, 4'd1, 4'd0, 4'd6, 1'b1, 1'b0);
        tick();
        set_id(C_ADD, 4'd6, 4'd6, 4'd1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (hz_stall !== 1'b0) begin
            miscompares++; $display("FAIL nfs_nouse_hz: got %0b expected 0", hz_stall);
        end
        tick();
        vectors++;
        if (obs !== exp_ex || EX_valid !== 1'b1) begin
            miscompares++; $display("FAIL nfs_nouse_ex: got %h expected %h", obs, exp_ex);
        end
    endtask

    task automatic test_hold_flush();
        ex_t held;
        logic [CNT_W-1:0] cnt0;
        set_id(C_ADD, 4'd2, 4'd3, 4'd8, 1'b1, 1'b1);
        tick();
        held = obs;
        cnt0 = stall_count;
        MEM_busy = 1'b1; ID_flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_id(C_LDR, 4'd9, 4'd9, 4'd9, 1'b1, 1'b1);
            #1;
            vectors++;
            if (hz_stall !== 1'b1) begin
                miscompares++; $display("FAIL hold_hz: got %0b expected 1", hz_stall);
            end
            tick();
            vectors++;
            if (obs !== held || obs !== exp_ex) begin
                miscompares++; $display("FAIL hold_ex: got %h expected %h", obs, held);
            end
        end
        MEM_busy = 1'b0;
        tick();
        vectors++;
        if (obs !== ex_t'(0) || stall_count !== cnt0) begin
            miscompares++; $display("FAIL flush_bubble: got %h cnt=%0d expected 0 cnt=%0d", obs, stall_count, cnt0);
        end
        ID_flush = 1'b0;
        set_id(C_LDR, 4'd1, 4'd0, 4'd9, 1'b1, 1'b0);
        tick();
        set_id(C_ADD, 4'd2, 4'd9, 4'd4, 1'b0, 1'b1);
        ID_flush = 1'b1;
        #1;
        vectors++;
        if (hz_stall !== 1'b1) begin
            miscompares++; $display("FAIL flush_lu_hz: got %0b expected 1", hz_stall);
        end
        tick();
        vectors++;
        if (EX_valid !== 1'b0 || stall_count !== cnt0) begin
            miscompares++; $display("FAIL flush_lu_cnt: got v=%0b cnt=%0d expected v=0 cnt=%0d", EX_valid, stall_count, cnt0);
        end
        ID_flush = 1'b0;
    endtask

    task automatic test_saturation();
        int want;
        CLR = 1'b0;
        tick();
        CLR = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_id(C_LDR, 4'd1, 4'd0, 4'd7, 1'b1, 1'b0);
            tick();
            set_id(C_ADD, 4'd7, 4'd0, 4'd8, 1'b1, 1'b0);
            tick();
            want = (i + 1 > 15) ? 15 : i + 1;
            vectors++;
            if (stall_count !== CNT_W'(want) || EX_valid !== 1'b0) begin
                miscompares++; $display("FAIL sat_step%0d: got cnt=%0d v=%0b expected cnt=%0d v=0", i, stall_count, EX_valid, want);
            end
        end
        vectors++;
        if (stall_count !== 4'hF) begin
            miscompares++; $display("FAIL sat_final: got %h expected f", stall_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] pick [5];
        logic [12:0] c;
        pick = '{4'd0, 4'd1, 4'd2, 4'd3, 4'hF};
        for (int n = 0; n < 500; n++) begin
            c = 13'($urandom);
            c[4] = ($urandom_range(0, 1) == 0);
            c[2] = ($urandom_range(0, 3) != 0);
            set_id(c, pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)],
                   pick[$urandom_range(0, 4)], 1'($urandom), 1'($urandom));
            CLR      = ($urandom_range(0, 39) != 0);
            MEM_busy = ($urandom_range(0, 5) == 0);
            ID_flush = ($urandom_range(0, 7) == 0);
            #1;
            vectors++;
            if (hz_stall !== (ref_lu() || MEM_busy)) begin
                miscompares++; $display("FAIL rnd_hz[%0d]: got %0b expected %0b", n, hz_stall, ref_lu() || MEM_busy);
            end
            tick();
            vectors++;
            if (obs !== exp_ex || stall_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL rnd_ex[%0d]: got %h cnt=%0d expected %h cnt=%0d", n, obs, stall_count, exp_ex, exp_cnt);
            end
        end
        CLR = 1'b1; MEM_busy = 1'b0; ID_flush = 1'b0;
    endtask

    initial begin
        exp_ex = '0;
        exp_cnt = '0;
        CLR = 1'b0;
        ID_flush = 1'b0;
        MEM_busy = 1'b0;
        set_id(C_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        #2;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_hold_flush();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
